imm_extend: RTL and testbench
=============================

# imm_extend

Registered immediate generator for the RV32I pipeline decode stage. It takes instruction bits [31:7] and a 2-bit immediate-format select from the control unit. It assembles the sign-extended 32-bit immediate for I, S, B or J formats and registers it into the decode/execute boundary. Stall and flush inputs let it behave as part of the pipeline register.

## Interface
- No parameters; all widths fixed (XLEN = 32).
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  25  instruction bits [31:7]; port bit k carries instruction bit k+7
- immsrc  input  2  format select: 00 I, 01 S, 10 B, 11 J
- valid_in  input  1  decode-stage instruction valid
- en  input  1  load enable; 0 = stall, hold all registers
- flush  input  1  synchronous clear (bubble insertion)
- immext  output  32  registered sign-extended immediate
- valid_out  output  1  registered valid_in

## Operation
- Combinational immediate, with i = full instruction bit index:
  - I (00): {{20{i31}}, i[31:20]}
  - S (01): {{20{i31}}, i[31:25], i[11:7]}
  - B (10): {{19{i31}}, i31, i7, i[30:25], i[11:8], 1'b0}
  - J (11): {{11{i31}}, i31, i[19:12], i20, i[30:21], 1'b0}
- Sign source is always i31; bit 0 of B and J immediates is always 0.
- Every immsrc code is defined; no X propagation for known inputs.
- Register update priority: rst_n low > flush > en > hold.
  - flush = 1: immext <= 0, valid_out <= 0, regardless of en.
  - en = 1, flush = 0: immext <= combinational immediate, valid_out <= valid_in.
  - en = 0, flush = 0: both registers hold.
- Immediate is computed regardless of valid_in; valid_in only gates valid_out.

## Timing
- Latency: 1 cycle. Inputs sampled on rising clk; immext and valid_out update on that edge.
- Throughput: one immediate per cycle while en = 1.
- Reset: rst_n low clears immext to 32'h00000000 and valid_out to 0 immediately, without waiting for clk.
  - Registers stay cleared while rst_n is low.
  - First load occurs on the first rising edge after rst_n deasserts.
- Reset mid-stream discards the in-flight immediate; no recovery of prior value.
- Flush and en both high: flush wins, output is cleared.
- Stall (en = 0) across any number of cycles holds immext and valid_out unchanged, even if instr or immsrc change.
- No combinational path from inputs to outputs.

## Test plan
- I-type: instr bits [31:20] = 0x015, rest 0, immsrc 00, en 1 -> one edge later immext = 0x00000015.
- S-type: instr bits [31:25] = 0010101, [24:20] = 00110, [11:7] = 0, immsrc 01 -> immext = 0x000002A0.
- B-type: full instruction 0xF1234F80, immsrc 10 -> immext = 0xFFFFFF1E.
- J-type:
  - All-zero instruction, immsrc 11 -> immext = 0x00000000.
  - Instruction 0x8000006F, immsrc 11 -> immext = 0xFFF00000.
- Control:
  - Load 0x00000015, then en = 0 with B-type stimulus for 3 cycles -> immext stays 0x00000015.
  - flush with en = 1 -> immext = 0, valid_out = 0 next edge.
- Async reset: drop rst_n mid-cycle with immext = 0xFFFFFF1E, valid_out = 1 -> both clear before the next clk edge. After release, the next edge loads new data.

Source files
------------

// File: rtl/imm_extend.sv
// Registered RV32I immediate generator for the decode/execute boundary.
// It builds the I/S/B/J sign-extended immediate and registers it with stall and flush control.
module imm_extend (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [24:0] instr,     // instruction bits [31:7]
   input  logic [1:0]  immsrc,
   input  logic        valid_in,
   input  logic        en,
   input  logic        flush,
   output logic [31:0] immext,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_fmt_t;

   // Field aliases in full-instruction numbering: port bit k is instruction bit k+7.
   logic        i31;
   logic [11:0] i_31_20;
   logic [6:0]  i_31_25;
   logic [5:0]  i_30_25;
   logic [9:0]  i_30_21;
   logic        i20;
   logic [7:0]  i_19_12;
   logic [4:0]  i_11_7;
   logic [3:0]  i_11_8;
   logic        i7;

   assign i31     = instr[24];
   assign i_31_20 = instr[24:13];
   assign i_31_25 = instr[24:18];
   assign i_30_25 = instr[23:18];
   assign i_30_21 = instr[23:14];
   assign i20     = instr[13];
   assign i_19_12 = instr[12:5];
   assign i_11_7  = instr[4:0];
   assign i_11_8  = instr[4:1];
   assign i7      = instr[0];

   logic [31:0] imm_comb;

   always_comb begin
      // NOTE: default assigned first so no path through the case can infer a latch.
      imm_comb = '0;
      unique case (imm_fmt_t'(immsrc))
         IMM_I: imm_comb = {{20{i31}}, i_31_20};
         IMM_S: imm_comb = {{20{i31}}, i_31_25, i_11_7};
         IMM_B: imm_comb = {{19{i31}}, i31, i7, i_30_25, i_11_8, 1'b0};
         IMM_J: imm_comb = {{11{i31}}, i31, i_19_12, i20, i_30_21, 1'b0};
      endcase
   end

   // Flush beats enable; with neither asserted the stage holds.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!rst_n) begin
         immext    <= '0;
         valid_out <= 1'b0;
      end else if (flush) begin
         immext    <= '0;
         valid_out <= 1'b0;
      end else if (en) begin
         immext    <= imm_comb;
         valid_out <= valid_in;
      end
   end

endmodule

// File: tb/tb_imm_extend.sv
// Self-checking bench for imm_extend: directed vector table, reset/stall corner sequences,
// and randomized traffic against an arithmetic reference model of the immediate formats.
module tb_imm_extend;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [24:0] instr;
   logic [1:0]  immsrc;
   logic        valid_in;
   logic        en;
   logic        flush;
   logic [31:0] immext;
   logic        valid_out;

   imm_extend dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .instr     (instr),
      .immsrc    (immsrc),
      .valid_in  (valid_in),
      .en        (en),
      .flush     (flush),
      .immext    (immext),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_imm;
   logic        exp_vld;

   typedef struct {
      string       name;
      logic [31:0] ins;
      logic [1:0]  src;
      logic        v;
      logic        e;
      logic        f;
      logic [31:0] exp_imm;
      logic        exp_vld;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Immediate value as a signed offset built from weighted instruction fields.
   function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] src);
      int s;
      int v;
      s = ins[31] ? 1 : 0;
      case (src)
         2'd0:    v = int'(ins[30:20]) - s * 2048;
         2'd1:    v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - s * 2048;
         2'd2:    v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - s * 4096;
         default: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                      - s * (1 << 20);
      endcase
      return 32'(v);
   endfunction

   // Drive one cycle of inputs, advance the model, and land 1 time unit past the edge.
   task automatic step(input logic [31:0] ins, input logic [1:0] src,
                       input logic v, input logic e, input logic f);
      instr    = ins[31:7];
      immsrc   = src;
      valid_in = v;
      en       = e;
      flush    = f;
      if (f) begin
         exp_imm = '0;
         exp_vld = 1'b0;
      end else if (e) begin
         exp_imm = ref_imm(ins, src);
         exp_vld = v;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      instr    = '0;
      immsrc   = '0;
      valid_in = 1'b0;
      en       = 1'b0;
      flush    = 1'b0;
      exp_imm  = '0;
      exp_vld  = 1'b0;

      vecs.push_back('{"i_pos",      32'h01500000, 2'd0, 1'b1, 1'b1, 1'b0, 32'h00000015, 1'b1});
      vecs.push_back('{"stall1",     32'hF1234F80, 2'd2, 1'b1, 1'b0, 1'b0, 32'h00000015, 1'b1});
      vecs.push_back('{"stall2",     32'hF1234F80, 2'd2, 1'b0, 1'b0, 1'b0, 32'h00000015, 1'b1});
      vecs.push_back('{"stall3",     32'h8000006F, 2'd3, 1'b0, 1'b0, 1'b0, 32'h00000015, 1'b1});
      vecs.push_back('{"s_type",     32'h2A600000, 2'd1, 1'b1, 1'b1, 1'b0, 32'h000002A0, 1'b1});
      vecs.push_back('{"b_type",     32'hF1234F80, 2'd2, 1'b1, 1'b1, 1'b0, 32'hFFFFFF1E, 1'b1});
      vecs.push_back('{"j_zero",     32'h00000000, 2'd3, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0});
      vecs.push_back('{"j_neg",      32'h8000006F, 2'd3, 1'b1, 1'b1, 1'b0, 32'hFFF00000, 1'b1});
      vecs.push_back('{"flush_en",   32'hF1234F80, 2'd2, 1'b1, 1'b1, 1'b1, 32'h00000000, 1'b0});
      vecs.push_back('{"i_neg1",     32'hFFF00000, 2'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{"flush_hold", 32'h01500000, 2'd0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0});
      vecs.push_back('{"i_novalid",  32'h80000000, 2'd0, 1'b0, 1'b1, 1'b0, 32'hFFFFF800, 1'b0});
      vecs.push_back('{"s_neg",      32'hFE000F80, 2'd1, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});

      // Reset state, with clock edges arriving while rst_n is low.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_imm", immext, 32'h0);
      check("rst_vld", {31'b0, valid_out}, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[k]) begin
         step(vecs[k].ins, vecs[k].src, vecs[k].v, vecs[k].e, vecs[k].f);
         check({vecs[k].name, "_imm"}, immext, vecs[k].exp_imm);
         check({vecs[k].name, "_vld"}, {31'b0, valid_out}, {31'b0, vecs[k].exp_vld});
      end

      // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
      step(32'hF1234F80, 2'd2, 1'b1, 1'b1, 1'b0);
      check("pre_rst_imm", immext, 32'hFFFFFF1E);
      check("pre_rst_vld", {31'b0, valid_out}, 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_imm", immext, 32'h0);
      check("async_rst_vld", {31'b0, valid_out}, 32'h0);
      instr    = 25'(32'h8000006F >> 7);
      immsrc   = 2'd3;
      valid_in = 1'b1;
      en       = 1'b1;
      @(posedge clk);
      #1;
      check("rst_held_imm", immext, 32'h0);
      check("rst_held_vld", {31'b0, valid_out}, 32'h0);
      rst_n   = 1'b1;
      exp_imm = '0;
      exp_vld = 1'b0;
      step(32'h01500000, 2'd0, 1'b1, 1'b1, 1'b0);
      check("post_rst_imm", immext, 32'h00000015);
      check("post_rst_vld", {31'b0, valid_out}, 32'h1);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r_ins;
         logic [1:0]  r_src;
         logic        r_v;
         logic        r_e;
         logic        r_f;
         r_ins = $urandom;
         r_src = 2'($urandom_range(0, 3));
         r_v   = 1'($urandom_range(0, 1));
         r_e   = ($urandom_range(0, 3) != 0);
         r_f   = ($urandom_range(0, 9) == 0);
         step(r_ins, r_src, r_v, r_e, r_f);
         check("rand_imm", immext, exp_imm);
         check("rand_vld", {31'b0, valid_out}, {31'b0, exp_vld});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
